// File: rtl/conv_1d_pkg.sv
// Shared types and sizing helpers for the 1-D convolution controller and datapath.
package conv_1d_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } conv_1d_ctrl_state_e;

    function automatic int conv_1d_result_w(input int img_w, input int filter_l, input int stride_w);
        return (img_w - filter_l) / stride_w + 1;
    endfunction

    // Address width for a memory of n entries, never narrower than one bit.
    function automatic int conv_1d_addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_1d_window_tracker.sv
// Counts columns shifted into the window register and flags each complete,
// stride-aligned window with the output column index it belongs to.
module conv_1d_window_tracker
    import conv_1d_pkg::*;
#(
    parameter int FILTER_L = 3,
    parameter int STRIDE_W = 1,
    parameter int RESULT_W = 30
) (
    input  logic                                  clk,
    input  logic                                  clr,
    input  logic                                  restart,
    input  logic                                  sr_wren,
    output logic                                  result_wren,
    output logic [conv_1d_addr_w(RESULT_W)-1:0]   result_wraddr
);

    localparam int CNT_W = $clog2(FILTER_L + 1);
    localparam int SW_W  = conv_1d_addr_w(STRIDE_W);
    localparam int RA_W  = conv_1d_addr_w(RESULT_W);

    localparam logic [CNT_W-1:0] FULL      = CNT_W'(FILTER_L);
    localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(FILTER_L - 1);
    localparam logic [SW_W-1:0]  RELOAD    = SW_W'(STRIDE_W - 1);

    logic [CNT_W-1:0] loaded_r;
    logic [SW_W-1:0]  stride_cnt_r;
    logic [RA_W-1:0]  out_idx_r;
    logic             window_s;

    // The write about to land completes a window: first fill, or stride counter expired.
    always_comb begin
        window_s = 1'b0;
        if (loaded_r == LAST_FILL) begin
            window_s = 1'b1;
        end else if ((loaded_r == FULL) && (stride_cnt_r == {SW_W{1'b0}})) begin
            window_s = 1'b1;
        end else begin
            window_s = 1'b0;
        end
    end

    // Column count, stride phase and output index; clr also drops the held address.
    always_ff @(posedge clk) begin
        if (clr) begin
            loaded_r      <= {CNT_W{1'b0}};
            stride_cnt_r  <= {SW_W{1'b0}};
            out_idx_r     <= {RA_W{1'b0}};
            result_wren   <= 1'b0;
            result_wraddr <= {RA_W{1'b0}};
        end else if (restart) begin
            loaded_r     <= {CNT_W{1'b0}};
            stride_cnt_r <= {SW_W{1'b0}};
            out_idx_r    <= {RA_W{1'b0}};
            result_wren  <= 1'b0;
        end else if (sr_wren) begin
            if (loaded_r != FULL) begin
                loaded_r <= loaded_r + CNT_W'(1);
            end
            if (window_s) begin
                stride_cnt_r  <= RELOAD;
                result_wraddr <= out_idx_r;
                out_idx_r     <= out_idx_r + RA_W'(1);
            end else if (loaded_r == FULL) begin
                stride_cnt_r <= stride_cnt_r - SW_W'(1);
            end
            result_wren <= window_s;
        end else begin
            result_wren <= 1'b0;
        end
    end

endmodule

// File: rtl/conv_bram_1d_ctrl.sv
// Pass controller for the 1-D convolution datapath: streams image columns and
// paces result writes. Optional cycle counter under CONV_1D_CTRL_PERF_EN.
module conv_bram_1d_ctrl
    import conv_1d_pkg::*;
#(
    parameter  int IMG_W                 = 32,
    parameter  int FILTER_L              = 3,
    parameter  int STRIDE_W              = 1,
    localparam int RESULT_W              = conv_1d_result_w(IMG_W, FILTER_L, STRIDE_W),
    localparam int IMG_RAM_ADDR_WIDTH    = $clog2(IMG_W),
    localparam int RESULT_RAM_ADDR_WIDTH = conv_1d_addr_w(RESULT_W)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             img_rden,
    output logic [IMG_RAM_ADDR_WIDTH-1:0]    img_rdaddr,
    output logic                             dpath_sr_wren,
    output logic [RESULT_RAM_ADDR_WIDTH-1:0] dpath_result_wraddr,
    output logic                             dpath_result_wren,
`ifdef CONV_1D_CTRL_PERF_EN
    output logic [31:0]                      perf_cycles,
`endif
    input  logic                             last_val
);

    localparam logic [IMG_RAM_ADDR_WIDTH-1:0] LAST_ADDR = IMG_RAM_ADDR_WIDTH'(IMG_W - 1);

    conv_1d_ctrl_state_e state_r;
    logic                lv_pend_r;
    logic                start_accept_s;

    assign start_accept_s = (state_r == IDLE) && start;

    // Pass sequencing; a last_val arriving on the RUN->DRAIN edge is kept in lv_pend_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            img_rden   <= 1'b0;
            img_rdaddr <= {IMG_RAM_ADDR_WIDTH{1'b0}};
            lv_pend_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r    <= RUN;
                        busy       <= 1'b1;
                        img_rden   <= 1'b1;
                        img_rdaddr <= {IMG_RAM_ADDR_WIDTH{1'b0}};
                    end
                end
                RUN: begin
                    if (img_rdaddr == LAST_ADDR) begin
                        state_r   <= DRAIN;
                        img_rden  <= 1'b0;
                        lv_pend_r <= last_val;
                    end else begin
                        img_rdaddr <= img_rdaddr + IMG_RAM_ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (last_val || lv_pend_r) begin
                        state_r   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        lv_pend_r <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    img_rden  <= 1'b0;
                    lv_pend_r <= 1'b0;
                end
            endcase
        end
    end

    // Read data arrives one cycle after the read, so the shift strobe trails rden.
    always_ff @(posedge clk) begin
        if (reset) begin
            dpath_sr_wren <= 1'b0;
        end else begin
            dpath_sr_wren <= img_rden;
        end
    end

    conv_1d_window_tracker #(
        .FILTER_L (FILTER_L),
        .STRIDE_W (STRIDE_W),
        .RESULT_W (RESULT_W)
    ) u_tracker (
        .clk           (clk),
        .clr           (reset),
        .restart       (start_accept_s),
        .sr_wren       (dpath_sr_wren),
        .result_wren   (dpath_result_wren),
        .result_wraddr (dpath_result_wraddr)
    );

`ifdef CONV_1D_CTRL_PERF_EN
    // Busy-cycle counter, cleared when a pass is accepted and held afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles <= 32'd0;
        end else if (start_accept_s) begin
            perf_cycles <= 32'd0;
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule
